keypad_scan_ctrl: RTL
=====================

Name: keypad_scan_ctrl

Overview:
- Single controller that sequences the 4x4 keypad.
- Drives the column strobes, samples the synchronized row lines, debounces press and release of exactly one key, and emits a one-cycle new-key pulse carrying the 4-bit hex code.
- Sits between the row synchronizer and the two-digit display storage; replaces the separate scanner and debouncer state machines with one arbitrated sequence.

Parameters:
- SCAN_DWELL, 48_000: cycles each column is held low before its rows are sampled (1 ms at 48 MHz).
- DEBOUNCE_CYCLES, 960_000: consecutive stable cycles required to accept a press or a release (20 ms at 48 MHz).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- row_keys  input  4  synchronized row lines, active-low (pulled up, 0 = key in driven column pressed)
- col_keys  output  4  column strobes, one-hot-low, exactly one bit 0 at all times
- key_valid  output  1  one-cycle pulse, new debounced key accepted
- key_code  output  4  hex code of last accepted key, held until next accept
- key_held  output  1  high from accept until debounced release completes

Behaviour:
- Reset (reset=0, async) values:
  - state=SCAN, column index=0, col_keys=4'b1110
  - dwell and debounce counters=0
  - key_valid=0, key_code=4'h0, key_held=0
- Counters: width $clog2(max(SCAN_DWELL, DEBOUNCE_CYCLES))+1; unsigned; cleared on every state change.
- SCAN:
  - Drive col_keys = ~(1<<idx); count dwell.
  - When dwell == SCAN_DWELL-1, sample row_keys.
  - If any bit is 0: latch idx as col_sel and the lowest-index low row as row_sel, go DEBOUNCE_PRESS.
  - Otherwise idx advances (3 wraps to 0) and dwell restarts.
- DEBOUNCE_PRESS:
  - col_keys held at col_sel.
  - If row_keys[row_sel]==1 on any cycle: return to SCAN, advancing idx.
  - Else count; on count == DEBOUNCE_CYCLES-1 go PRESSED.
  - On that same edge: key_valid=1 for exactly one cycle, key_code=lookup(row_sel,col_sel), key_held=1.
- PRESSED:
  - col_keys held at col_sel; key_held=1.
  - Other keys, in any row or column, are ignored.
  - row_keys[row_sel]==1 -> RELEASE_DB.
- RELEASE_DB:
  - If row_keys[row_sel]==0 on any cycle (bounce): return to PRESSED, no new key_valid.
  - On count == DEBOUNCE_CYCLES-1 of continuous high: key_held=0, go SCAN with idx=col_sel+1 (wrap).
- Key map (row r, col c):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- Boundaries:
  - Multiple rows low in one column: lowest row index wins.
  - Two keys in different columns: the first scanned wins; the second is never reported while the first is held.
  - A second key still held after release of the first is detected by normal scanning and reported once.
  - key_valid never asserts twice without a completed release.
  - Reset mid-debounce or mid-hold: immediate return to reset values, no pulse.
  - key_code holds its value across release and scanning.

Decomposition:
- Package keypad_pkg:
  - state enum (SCAN, DEBOUNCE_PRESS, PRESSED, RELEASE_DB), 2-bit
  - the 16-entry key map constant, indexed {row,col}
  - column-strobe function ~(4'b1<<idx)
- One sub-module, keypad_code_lut: combinational row_sel/col_sel -> hex code using the package constant.
- Counters and FSM stay in keypad_scan_ctrl.

Test Plan (SCAN_DWELL=4, DEBOUNCE_CYCLES=8 in bench):
- Reset released, no keys -> col_keys cycles 1110,1101,1011,0111,1110 every 4 cycles; key_valid never asserts; key_code=0.
- Key '6' (r1,c2) held 50 cycles then released -> col_keys stays 1011; one key_valid pulse 8 cycles after detection; key_code=4'h6; key_held falls 8 cycles after release.
- Press bounce: row low 3 cycles, high 1, low steady -> first attempt aborts to SCAN with no pulse; later a single pulse with the correct code.
- Release bounce: during RELEASE_DB row goes low at count 5 -> back to PRESSED, no extra pulse; key_held stays 1.
- '1' held, then 'D' pressed, then '1' released -> pulse for 4'h1 only while '1' held; after release debounce, one pulse with 4'hD.
- Reset asserted mid-DEBOUNCE_PRESS -> outputs immediately col_keys=1110, key_valid=0, key_held=0, key_code=0.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scan controller.
package keypad_pkg;

  // Controller sequence: scan columns, debounce a press, hold, debounce the release.
  typedef enum logic [1:0] {
    StScan          = 2'd0,
    StDebouncePress = 2'd1,
    StPressed       = 2'd2,
    StReleaseDb     = 2'd3
  } state_e;

  // Hex code per key, indexed {row, col}; element 0 (row 0, col 0) is rightmost.
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hF, 4'h0, 4'hE,   // row 3
    4'hC, 4'h9, 4'h8, 4'h7,   // row 2
    4'hB, 4'h6, 4'h5, 4'h4,   // row 1
    4'hA, 4'h3, 4'h2, 4'h1    // row 0
  };

  // One-hot-low column strobe for column idx.
  function automatic logic [3:0] col_strobe(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// Keypad-facing and host-facing signals of the scan controller.
interface keypad_scan_ctrl_if;
  logic [3:0] row_keys;   // synchronized rows, active-low
  logic [3:0] col_keys;   // column strobes, one-hot-low
  logic       key_valid;  // one-cycle pulse on accepted key
  logic [3:0] key_code;   // last accepted hex code
  logic       key_held;   // accepted key not yet released

  // Controller side.
  modport master (
    input  row_keys,
    output col_keys,
    output key_valid,
    output key_code,
    output key_held
  );

  // Keypad / consumer side.
  modport slave (
    output row_keys,
    input  col_keys,
    input  key_valid,
    input  key_code,
    input  key_held
  );
endinterface

// File: rtl/keypad_code_lut.sv
// Combinational translation of the selected row/column into its hex key code.
module keypad_code_lut
  import keypad_pkg::*;
(
  input  logic [1:0] row_sel,
  input  logic [1:0] col_sel,
  output logic [3:0] code
);

  // Table lookup into the shared key map.
  always_comb begin
    code = KEY_MAP[{row_sel, col_sel}];
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad controller: column scanning, press/release debounce of a single
// key, and a one-cycle new-key pulse carrying the key's hex code.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DWELL      = 48_000,
  parameter int unsigned DEBOUNCE_CYCLES = 960_000
) (
  input logic          clk,
  input logic          reset,
  keypad_scan_ctrl_if.master bus
);

  localparam int unsigned CNT_MAX = (SCAN_DWELL > DEBOUNCE_CYCLES) ? SCAN_DWELL
                                                                  : DEBOUNCE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DWELL - 1);
  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_e           state;
  logic [1:0]       idx;
  logic [1:0]       col_sel;
  logic [1:0]       row_sel;
  logic [CNT_W-1:0] dwell_cnt;
  logic [CNT_W-1:0] db_cnt;
  logic [3:0]       col_keys_q;
  logic [3:0]       key_code_q;
  logic             key_valid_q;
  logic             key_held_q;

  logic             any_low;
  logic [1:0]       low_row;
  logic             sel_row_high;
  logic [1:0]       next_col;
  logic [3:0]       lut_code;

  // Find the lowest-index active row and track the selected row's level.
  always_comb begin
    any_low = ~&bus.row_keys;
    low_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!bus.row_keys[i]) begin
        low_row = 2'(i);
      end
    end
    sel_row_high = bus.row_keys[row_sel];
    next_col     = col_sel + 2'd1;
  end

  keypad_code_lut u_code_lut (
    .row_sel (row_sel),
    .col_sel (col_sel),
    .code    (lut_code)
  );

  // Single sequencer: every state change clears both counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= StScan;
      idx         <= 2'd0;
      col_sel     <= 2'd0;
      row_sel     <= 2'd0;
      dwell_cnt   <= '0;
      db_cnt      <= '0;
      col_keys_q  <= 4'b1110;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'h0;
      key_held_q  <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      unique case (state)
        StScan: begin
          if (dwell_cnt == DWELL_LAST) begin
            dwell_cnt <= '0;
            if (any_low) begin
              col_sel <= idx;
              row_sel <= low_row;
              db_cnt  <= '0;
              state   <= StDebouncePress;
            end else begin
              idx        <= idx + 2'd1;
              col_keys_q <= col_strobe(idx + 2'd1);
            end
          end else begin
            dwell_cnt <= dwell_cnt + CNT_ONE;
          end
        end

        StDebouncePress: begin
          if (sel_row_high) begin
            // Bounce: abandon this key and resume scanning past its column.
            idx        <= next_col;
            col_keys_q <= col_strobe(next_col);
            dwell_cnt  <= '0;
            db_cnt     <= '0;
            state      <= StScan;
          end else if (db_cnt == DB_LAST) begin
            db_cnt      <= '0;
            key_valid_q <= 1'b1;
            key_code_q  <= lut_code;
            key_held_q  <= 1'b1;
            state       <= StPressed;
          end else begin
            db_cnt <= db_cnt + CNT_ONE;
          end
        end

        StPressed: begin
          // Column stays on the held key, so other keys cannot be seen.
          if (sel_row_high) begin
            db_cnt    <= '0;
            dwell_cnt <= '0;
            state     <= StReleaseDb;
          end
        end

        StReleaseDb: begin
          if (!sel_row_high) begin
            db_cnt    <= '0;
            dwell_cnt <= '0;
            state     <= StPressed;
          end else if (db_cnt == DB_LAST) begin
            key_held_q <= 1'b0;
            idx        <= next_col;
            col_keys_q <= col_strobe(next_col);
            db_cnt     <= '0;
            dwell_cnt  <= '0;
            state      <= StScan;
          end else begin
            db_cnt <= db_cnt + CNT_ONE;
          end
        end

        default: begin
          state <= StScan;
        end
      endcase
    end
  end

  assign bus.col_keys  = col_keys_q;
  assign bus.key_valid = key_valid_q;
  assign bus.key_code  = key_code_q;
  assign bus.key_held  = key_held_q;

endmodule
